// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, HI/LO registers, optional divider.
// Define EX_DIV_EN to build the 32-step restoring divider; without it DIV/DIVU are NOPs.
package ex_stage_pkg;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
endpackage

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    logic [DIV_ITERS-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0]          alu_res;
    logic                 alu_valid;
    logic                 div_stall;

    always_comb begin
        // NOTE: every signal written here gets a default first; a missed branch would otherwise infer a latch.
        alu_res   = '0;
        alu_valid = 1'b1;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  alu_res = reg1_i | reg2_i;
                    EXE_AND_OP: alu_res = reg1_i & reg2_i;
                    EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
                    EXE_NOR_OP: alu_res = ~(reg1_i | reg2_i);
                    default:    alu_valid = 1'b0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADDU_OP: alu_res = reg1_i + reg2_i;
                    EXE_SUBU_OP: alu_res = reg1_i - reg2_i;
                    EXE_SLT_OP:  alu_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    EXE_SLTU_OP: alu_res = {31'd0, reg1_i < reg2_i};
                    default:     alu_valid = 1'b0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: alu_res = hi_q;
                    EXE_MFLO_OP: alu_res = lo_q;
                    default:     alu_valid = 1'b0;
                endcase
            end
            default: alu_valid = 1'b0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    localparam int CW = $clog2(DIV_ITERS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV_ITERS - 1);

    div_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic           neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [32:0]    partial, diff;
    logic [31:0]    step_rem, step_quo;
    logic           is_div, is_signed;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_stall = 1'b0;
        is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
        is_signed = (aluop_i == EXE_DIV_OP);

        // One restoring step: shift the next dividend bit into the partial remainder, try to subtract.
        partial = {rem_q, quo_q[31]};
        diff    = partial - {1'b0, dvs_q};
        if (!diff[32]) begin
            step_rem = diff[31:0];
            step_quo = {quo_q[30:0], 1'b1};
        end else begin
            step_rem = partial[31:0];
            step_quo = {quo_q[30:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (is_div && reg2_i != '0) begin
                    quo_d     = (is_signed && reg1_i[31]) ? -reg1_i : reg1_i;
                    dvs_d     = (is_signed && reg2_i[31]) ? -reg2_i : reg2_i;
                    neg_quo_d = is_signed && (reg1_i[31] ^ reg2_i[31]);
                    neg_rem_d = is_signed && reg1_i[31];
                    rem_d     = '0;
                    cnt_d     = '0;
                    div_stall = 1'b1;
                    state_d   = BUSY;
                end else if (is_div) begin
                    hi_d = reg1_i;
                    lo_d = '1;
                end
            end
            BUSY: begin
                div_stall = 1'b1;
                rem_d     = step_rem;
                quo_d     = step_quo;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    hi_d    = neg_rem_q ? -step_rem : step_rem;
                    lo_d    = neg_quo_q ? -step_quo : step_quo;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flush cancels the divide outright, including a write due on the last step.
        if (flush_i) begin
            state_d   = IDLE;
            div_stall = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the divider datapath has no reset; it is always loaded in IDLE before BUSY reads it.
    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvs_q     <= dvs_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end
`else
    assign div_stall = 1'b0;
    assign hi_d      = hi_q;
    assign lo_d      = lo_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign wd_o       = rst ? 5'd0 : wd_i;
    assign wreg_o     = !rst && !flush_i && wreg_i && alu_valid;
    assign wdata_o    = rst ? 32'd0 : alu_res;
    assign stallreq_o = !rst && div_stall;
    assign hi_o       = rst ? 32'd0 : hi_q;
    assign lo_o       = rst ? 32'd0 : lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divide checks follow the EX_DIV_EN build option.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i), .wd_i(wd_i),
        .wreg_i(wreg_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .flush_i(flush_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd, input logic wr);
        alusel_i = sel;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
        flush_i  = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        @(negedge clk);
        set_in(sel, op, a, b, wd, wr);
        #1;
    endtask

    task automatic nop();
        apply(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Issue a divide and hold it until stall drops; returns in the first non-stalled cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int stalls, output logic wreg_seen);
        apply(EXE_RES_NOP, op, a, b, 5'd7, 1'b1);
        stalls    = 0;
        wreg_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!stallreq_o) break;
            stalls++;
            wreg_seen = wreg_seen | wreg_o;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int   stalls;
        logic wseen;

        rst = 1'b1;
        set_in(EXE_RES_LOGIC, EXE_OR_OP, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
        @(negedge clk);
        #1;
        check("rst_wd", {27'd0, wd_o}, 32'd0);
        check("rst_wreg", {31'd0, wreg_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stall", {31'd0, stallreq_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply(EXE_RES_LOGIC, EXE_OR_OP, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
        check("ori_wdata", wdata_o, 32'h0000_1111);
        check("ori_wd", {27'd0, wd_o}, 32'd3);
        check("ori_wreg", {31'd0, wreg_o}, 32'd1);
        apply(EXE_RES_LOGIC, EXE_AND_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4, 1'b1);
        check("and", wdata_o, 32'hF000_F000);
        apply(EXE_RES_LOGIC, EXE_XOR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4, 1'b1);
        check("xor", wdata_o, 32'h0FF0_0FF0);
        apply(EXE_RES_LOGIC, EXE_NOR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4, 1'b1);
        check("nor", wdata_o, 32'h000F_000F);
        apply(EXE_RES_ARITH, EXE_ADDU_OP, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9, 1'b1);
        check("addu_wrap", wdata_o, 32'h0000_0001);
        check("addu_wd", {27'd0, wd_o}, 32'd9);
        apply(EXE_RES_ARITH, EXE_SUBU_OP, 32'h0000_0000, 32'h0000_0001, 5'd9, 1'b1);
        check("subu_wrap", wdata_o, 32'hFFFF_FFFF);
        apply(EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 1'b1);
        check("slt_neg", wdata_o, 32'd1);
        apply(EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 1'b1);
        check("sltu_big", wdata_o, 32'd0);
        apply(EXE_RES_ARITH, EXE_SLTU_OP, 32'h0000_0001, 32'hFFFF_FFFF, 5'd9, 1'b1);
        check("sltu_small", wdata_o, 32'd1);
        apply(EXE_RES_LOGIC, 8'hFF, 32'h1234_5678, 32'h0000_FFFF, 5'd9, 1'b1);
        check("unknown_wdata", wdata_o, 32'd0);
        check("unknown_wreg", {31'd0, wreg_o}, 32'd0);
        apply(EXE_RES_ARITH, EXE_ADDU_OP, 32'd1, 32'd2, 5'd9, 1'b1);
        flush_i = 1'b1;
        #1;
        check("flush_wreg", {31'd0, wreg_o}, 32'd0);
        apply(EXE_RES_MOVE, EXE_MFHI_OP, 32'd0, 32'd0, 5'd2, 1'b1);
        check("mfhi_reset", wdata_o, 32'd0);
        apply(EXE_RES_MOVE, EXE_MFLO_OP, 32'd0, 32'd0, 5'd2, 1'b1);
        check("mflo_reset", wdata_o, 32'd0);

`ifdef EX_DIV_EN
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, stalls, wseen);
        check("div_stall_cycles", stalls, 32'd33);
        check("div_wreg", {31'd0, wseen | wreg_o}, 32'd0);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);
        apply(EXE_RES_MOVE, EXE_MFLO_OP, 32'd0, 32'd0, 5'd2, 1'b1);
        check("mflo_after_div", wdata_o, 32'hFFFF_FFFD);
        check("no_restart", {31'd0, stallreq_o}, 32'd0);
        apply(EXE_RES_MOVE, EXE_MFHI_OP, 32'd0, 32'd0, 5'd2, 1'b1);
        check("mfhi_after_div", wdata_o, 32'hFFFF_FFFF);

        run_div(EXE_DIVU_OP, 32'd100, 32'd7, stalls, wseen);
        check("divu_stall_cycles", stalls, 32'd33);
        check("divu_lo", lo_o, 32'd14);
        check("divu_hi", hi_o, 32'd2);
        run_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, stalls, wseen);
        check("div_negdvs_lo", lo_o, 32'hFFFF_FFFD);
        check("div_negdvs_hi", hi_o, 32'd1);
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, stalls, wseen);
        check("div_ovf_lo", lo_o, 32'h8000_0000);
        check("div_ovf_hi", hi_o, 32'd0);

        apply(EXE_RES_NOP, EXE_DIV_OP, 32'd5, 32'd0, 5'd7, 1'b1);
        check("div0_stall", {31'd0, stallreq_o}, 32'd0);
        check("div0_wreg", {31'd0, wreg_o}, 32'd0);
        nop();
        check("div0_hi", hi_o, 32'd5);
        check("div0_lo", lo_o, 32'hFFFF_FFFF);

        run_div(EXE_DIVU_OP, 32'd5, 32'd2, stalls, wseen);
        check("preload_hi", hi_o, 32'd1);
        check("preload_lo", lo_o, 32'd2);
        apply(EXE_RES_NOP, EXE_DIV_OP, 32'd100, 32'd7, 5'd7, 1'b1);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush_busy_stall", {31'd0, stallreq_o}, 32'd0);
        check("flush_busy_wreg", {31'd0, wreg_o}, 32'd0);
        nop();
        check("flush_idle_stall", {31'd0, stallreq_o}, 32'd0);
        check("flush_hi", hi_o, 32'd1);
        check("flush_lo", lo_o, 32'd2);
        apply(EXE_RES_NOP, EXE_DIVU_OP, 32'd8, 32'd0, 5'd7, 1'b1);
        nop();
        check("flush_then_idle_hi", hi_o, 32'd8);
        check("flush_then_idle_lo", lo_o, 32'hFFFF_FFFF);

        apply(EXE_RES_NOP, EXE_DIVU_OP, 32'd100, 32'd7, 5'd7, 1'b1);
        repeat (32) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush_last_stall", {31'd0, stallreq_o}, 32'd0);
        nop();
        check("flush_last_hi", hi_o, 32'd8);
        check("flush_last_lo", lo_o, 32'hFFFF_FFFF);

        apply(EXE_RES_NOP, EXE_DIV_OP, 32'd100, 32'd7, 5'd7, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstdiv_wd", {27'd0, wd_o}, 32'd0);
        check("rstdiv_wreg", {31'd0, wreg_o}, 32'd0);
        check("rstdiv_wdata", wdata_o, 32'd0);
        check("rstdiv_stall", {31'd0, stallreq_o}, 32'd0);
        check("rstdiv_hi", hi_o, 32'd0);
        check("rstdiv_lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        check("post_rst_stall", {31'd0, stallreq_o}, 32'd0);
        check("post_rst_hi", hi_o, 32'd0);
        check("post_rst_lo", lo_o, 32'd0);
        run_div(EXE_DIVU_OP, 32'd9, 32'd3, stalls, wseen);
        check("post_rst_div_stalls", stalls, 32'd33);
        check("post_rst_div_lo", lo_o, 32'd3);
        check("post_rst_div_hi", hi_o, 32'd0);
`else
        apply(EXE_RES_NOP, EXE_DIV_OP, 32'd100, 32'd7, 5'd7, 1'b1);
        check("nodiv_stall", {31'd0, stallreq_o}, 32'd0);
        check("nodiv_wreg", {31'd0, wreg_o}, 32'd0);
        apply(EXE_RES_NOP, EXE_DIVU_OP, 32'd5, 32'd0, 5'd7, 1'b1);
        check("nodiv0_stall", {31'd0, stallreq_o}, 32'd0);
        nop();
        check("nodiv_hi", hi_o, 32'd0);
        check("nodiv_lo", lo_o, 32'd0);
        apply(EXE_RES_MOVE, EXE_MFHI_OP, 32'd0, 32'd0, 5'd2, 1'b1);
        check("nodiv_mfhi", wdata_o, 32'd0);
        check("nodiv_mfhi_wreg", {31'd0, wreg_o}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage, fed through the ID/EX register.
- Consumes aluop/alusel/operands/destination and produces the write-back triple (wd, wreg, wdata).
- That triple goes both to EX/MEM and back to decode as the EX forwarding path.
- Holds the HI/LO registers and a 32-iteration restoring divider. While a divide is running, it stalls upstream stages.

Parameters:
- DIV_ITERS, 32, number of divider iterations. Must equal the data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- aluop_i  in  8  operation subtype from decode (EXE_*_OP)
- alusel_i  in  3  result class from decode (EXE_RES_*)
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- reg1_i  in  32  source operand 1
- reg2_i  in  32  source operand 2
- flush_i  in  1  pipeline flush: cancel the instruction in EX
- wd_o  out  5  destination address to EX/MEM and decode forwarding
- wreg_o  out  1  write enable to EX/MEM and decode forwarding
- wdata_o  out  32  result to EX/MEM and decode forwarding
- stallreq_o  out  1  request to hold PC, IF/ID and ID/EX
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous, active-high.
  - On rst: FSM goes to IDLE, counter=0, HI=LO=0.
  - While rst=1, all outputs are 0: wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o.
- Single-cycle ops (combinational, same cycle as inputs):
  - EXE_RES_LOGIC:
    - EXE_OR_OP: reg1|reg2
    - EXE_AND_OP: reg1&reg2
    - EXE_XOR_OP: reg1^reg2
    - EXE_NOR_OP: ~(reg1|reg2)
  - EXE_RES_ARITH:
    - EXE_ADDU_OP: reg1+reg2, mod 2^32
    - EXE_SUBU_OP: reg1-reg2, mod 2^32
    - EXE_SLT_OP: signed compare, result 1 or 0
    - EXE_SLTU_OP: unsigned compare, result 1 or 0
  - EXE_RES_MOVE:
    - EXE_MFHI_OP returns HI; EXE_MFLO_OP returns LO.
  - wd_o=wd_i and wreg_o=wreg_i for all of the above.
  - Unknown aluop: wdata_o=0 and wreg_o=0.
- Divide (EXE_DIV_OP signed, EXE_DIVU_OP unsigned):
  - wreg_o=0 throughout; the result goes only to HI (remainder) and LO (quotient).
  - FSM states: IDLE, BUSY, DONE.
  - IDLE, divide op present, reg2≠0:
    - Latch |dividend|, |divisor| (raw values for DIVU) and sign flags; counter=0.
    - stallreq_o=1; next state BUSY.
  - IDLE, divide op present, reg2=0:
    - No stall. At the next edge write HI=reg1, LO=32'hFFFFFFFF.
    - Stay in IDLE.
  - BUSY:
    - stallreq_o=1. Each cycle runs one shift/subtract step and increments the counter.
    - On the step where counter=DIV_ITERS-1, apply sign fixup and write HI/LO at that edge; next state DONE.
    - Sign fixup: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - DONE:
    - stallreq_o=0, so the pipeline advances past the divide this cycle. The divide still on the inputs is not restarted.
    - Next state IDLE.
  - Latency: stallreq_o is high for exactly 33 cycles (1 IDLE + 32 BUSY). HI/LO are visible from the DONE cycle onward.
  - A MFHI/MFLO directly following a divide reads the new values with no hazard.
- flush_i:
  - Any state goes to IDLE; stallreq_o=0 that same cycle.
  - HI/LO are not written; wreg_o=0 that cycle.
  - A flush during the last BUSY cycle takes priority over the HI/LO write.
- Reset mid-divide behaves like flush, and also clears HI/LO.
- Overflow: 0x80000000 / -1 (signed) gives LO=0x80000000, HI=0. No trap.

Optional Feature:
- Macro: EX_DIV_EN.
- Defined: divider and FSM are built as described above.
- Undefined:
  - No divider logic; EXE_DIV_OP and EXE_DIVU_OP act as a NOP.
  - wreg_o=0, HI/LO unchanged, stallreq_o tied 0.
  - MFHI/MFLO still return HI/LO, which stay at 0 after reset.

Test Plan:
- ORI result: alusel=LOGIC, aluop=OR, reg1=0x00001100, reg2=0x00000011, wd=3, wreg=1 -> same cycle wdata_o=0x00001111, wd_o=3, wreg_o=1.
- Arithmetic: SUBU with 0x00000000 - 0x00000001 -> wdata_o=0xFFFFFFFF. SLT with 0xFFFFFFFF vs 0x00000001 -> 1. SLTU with same operands -> 0.
- Signed divide: DIV with -7 (0xFFFFFFF9) / 2:
  - stallreq_o high for exactly 33 cycles; wreg_o=0 throughout.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - A following MFLO gives wdata_o=0xFFFFFFFD.
- Unsigned divide and divide-by-zero:
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV 5/0 -> no stall; next cycle HI=5, LO=0xFFFFFFFF.
- Flush mid-divide: start DIV 100/7 with HI/LO preloaded to 1/2, assert flush_i in BUSY cycle 10 -> stallreq_o drops that cycle, HI=1, LO=2 unchanged, FSM IDLE.
- Reset mid-divide: assert rst in BUSY cycle 20 -> next cycle all outputs 0, HI=LO=0. A new DIVU 9/3 then completes normally with LO=3, HI=0.
